// File: rtl/m_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : m_store_buffer
// Description : Posted-write FIFO between the M-stage store formatter and the
//               system bridge. Retires stores in order over a req/ack
//               handshake and flags M-stage loads overlapping a pending store.
//               Optional macro STBUF_MERGE_EN merges a store into the tail
//               entry when both target the same word.
// Revision    : 1.0 - initial release
// ============================================================================
module m_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [3:0]       st_byteen,
    input  logic [31:0]      st_wdata,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic [3:0]       ld_byteen,
    output logic             ld_stall,
    output logic             bus_req,
    output logic [31:0]      bus_addr,
    output logic [3:0]       bus_byteen,
    output logic [31:0]      bus_wdata,
    input  logic             bus_ack,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [29:0]       addr_mem [DEPTH];
    logic [3:0]        be_mem   [DEPTH];
    logic [31:0]       data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              merge_hit;
    logic              push;
    logic              alloc;
    logic              pop;
    logic [DEPTH-1:0]  entry_valid;
    logic [DEPTH-1:0]  entry_hit;

    // Byte-offset bits of the addresses are irrelevant to a word buffer.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

`ifdef STBUF_MERGE_EN
    logic [PTR_W-1:0]  tail_ptr;
    logic              merge;
    assign tail_ptr  = wr_ptr - PTR_W'(1);
    // The tail may only absorb a store when it is not also the offered head.
    assign merge_hit = (count >= (PTR_W + 1)'(2)) && (addr_mem[tail_ptr] == st_addr[31:2]);
    assign merge     = push && merge_hit;
`else
    assign merge_hit = 1'b0;
`endif

    // Readiness comes from the registered count only; a merging store never needs a slot.
    assign st_ready = (count != CNT_FULL) || merge_hit;
    assign push     = st_valid && st_ready && (st_byteen != 4'b0000);
    assign alloc    = push && !merge_hit;
    assign pop      = bus_req && bus_ack;

    assign bus_req    = (count != '0);
    assign empty      = (count == '0);
    assign bus_addr   = bus_req ? {addr_mem[rd_ptr], 2'b00} : 32'h0;
    assign bus_byteen = bus_req ? be_mem[rd_ptr] : 4'h0;
    assign bus_wdata  = bus_req ? data_mem[rd_ptr] : 32'h0;

    // Pointer and occupancy bookkeeping; reset discards everything, even a head mid-handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (alloc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({alloc, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload writes: new allocation at wr_ptr, or lane-wise merge into the tail.
    always_ff @(posedge clk) begin
        if (reset && alloc) begin
            addr_mem[wr_ptr] <= st_addr[31:2];
            be_mem[wr_ptr]   <= st_byteen;
            data_mem[wr_ptr] <= st_wdata;
        end
`ifdef STBUF_MERGE_EN
        else if (reset && merge) begin
            be_mem[tail_ptr] <= be_mem[tail_ptr] | st_byteen;
            for (int l = 0; l < 4; l++) begin
                if (st_byteen[l]) data_mem[tail_ptr][8*l +: 8] <= st_wdata[8*l +: 8];
            end
        end
`endif
    end

    // An entry is live when its distance from the head is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] offset;
        assign offset         = PTR_W'(i) - rd_ptr;
        assign entry_valid[i] = ({1'b0, offset} < count);
        assign entry_hit[i]   = entry_valid[i]
                              && (addr_mem[i] == ld_addr[31:2])
                              && ((be_mem[i] & ld_byteen) != 4'b0000);
    end

    assign ld_stall = ld_valid && (|entry_hit);

endmodule
`default_nettype wire

// File: tb/tb_m_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_store_buffer
// Description : Self-checking bench for m_store_buffer with a queue-based
//               reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_store_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
`ifdef STBUF_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           st_valid;
    logic [31:0]    st_addr;
    logic [3:0]     st_byteen;
    logic [31:0]    st_wdata;
    logic           st_ready;
    logic           ld_valid;
    logic [31:0]    ld_addr;
    logic [3:0]     ld_byteen;
    logic           ld_stall;
    logic           bus_req;
    logic [31:0]    bus_addr;
    logic [3:0]     bus_byteen;
    logic [31:0]    bus_wdata;
    logic           bus_ack;
    logic           empty;
    logic [PTR_W:0] count;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    m_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_byteen(st_byteen),
        .st_wdata(st_wdata), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byteen(ld_byteen),
        .ld_stall(ld_stall),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_byteen(bus_byteen),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .empty(empty), .count(count)
    );

    function automatic bit model_merge_hit();
        if (!MERGE || q.size() < 2) return 1'b0;
        return q[$].a == st_addr[31:2];
    endfunction

    function automatic bit model_ready();
        return (q.size() < DEPTH) || model_merge_hit();
    endfunction

    // Applies the buffer rules to the queue for the coming clock edge.
    function automatic void model_step();
        bit   do_pop, do_push, do_merge;
        ent_t t;
        if (!reset) begin
            q.delete();
            return;
        end
        do_pop   = (q.size() != 0) && bus_ack;
        do_push  = st_valid && model_ready() && (st_byteen != 4'b0000);
        do_merge = do_push && model_merge_hit();
        if (do_merge) begin
            t = q[$];
            for (int l = 0; l < 4; l++)
                if (st_byteen[l]) t.d[8*l +: 8] = st_wdata[8*l +: 8];
            t.be = t.be | st_byteen;
            q[$] = t;
        end else if (do_push) begin
            t.a = st_addr[31:2]; t.be = st_byteen; t.d = st_wdata;
            q.push_back(t);
        end
        if (do_pop) void'(q.pop_front());
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic v, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        st_valid = v; st_addr = a; st_byteen = be; st_wdata = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h0000_1004; ld_byteen = 4'hF;
        #1;
        total++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req: got %b want 0", bus_req); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed++;
        total++; if (st_ready !== 1'b1) $display("FAIL reset_st_ready: got %b want 1", st_ready); else passed++;
        total++; if (ld_stall !== 1'b0) $display("FAIL reset_ld_stall: got %b want 0", ld_stall); else passed++;
        total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        ld_valid = 1'b0;
    endtask

    task automatic test_single();
        set_store(1'b1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF);
        tick();
        set_store(1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        total++; if (bus_req !== 1'b1) $display("FAIL single_req: got %b want 1", bus_req); else passed++;
        total++; if (bus_addr !== 32'h0000_1004) $display("FAIL single_addr: got %h want 00001004", bus_addr); else passed++;
        total++; if (count !== 3'd1) $display("FAIL single_count: got %0d want 1", count); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({bus_req, bus_addr, bus_byteen, bus_wdata} !== {1'b1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF})
                $display("FAIL single_stable%0d: got %b %h %h %h want 1 00001004 f deadbeef", i, bus_req, bus_addr, bus_byteen, bus_wdata);
            else passed++;
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        total++; if (empty !== 1'b1) $display("FAIL single_empty_after_ack: got %b want 1", empty); else passed++;
        total++; if ({bus_req, bus_addr} !== 33'h0) $display("FAIL single_bus_idle: got %b %h want 0 00000000", bus_req, bus_addr); else passed++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_store(1'b1, 32'h10 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i));
            tick();
        end
        set_store(1'b1, 32'h20, 4'hF, 32'hA000_0004);
        #1;
        total++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count); else passed++;
        total++; if (st_ready !== 1'b0) $display("FAIL full_st_ready: got %b want 0", st_ready); else passed++;
        tick();
        total++; if (count !== 3'd4) $display("FAIL full_fifth_held: got %0d want 4", count); else passed++;
        total++; if (bus_addr !== 32'h10) $display("FAIL full_head: got %h want 00000010", bus_addr); else passed++;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        total++; if (st_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b want 1", st_ready); else passed++;
        total++; if (bus_addr !== 32'h14) $display("FAIL full_next_head: got %h want 00000014", bus_addr); else passed++;
        tick();
        set_store(1'b0, 32'h0, 4'h0, 32'h0);
        bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bus_addr !== 32'h14 + 32'(4 * i) || bus_wdata !== 32'hA000_0001 + 32'(i))
                $display("FAIL full_drain%0d: got %h/%h want %h/%h", i, bus_addr, bus_wdata, 32'h14 + 32'(4 * i), 32'hA000_0001 + 32'(i));
            else passed++;
            tick();
        end
        bus_ack = 1'b0;
        #1;
        total++; if (empty !== 1'b1) $display("FAIL full_drained_empty: got %b want 1", empty); else passed++;
    endtask

    task automatic test_hazard();
        set_store(1'b1, 32'h0000_2002, 4'b0100, 32'h00AB_0000);
        tick();
        set_store(1'b0, 32'h0, 4'h0, 32'h0);
        ld_valid = 1'b1; ld_addr = 32'h0000_2000; ld_byteen = 4'hF;
        #1;
        total++; if (ld_stall !== 1'b1) $display("FAIL hazard_lw_overlap: got %b want 1", ld_stall); else passed++;
        ld_addr = 32'h0000_2001; ld_byteen = 4'b0010;
        #1;
        total++; if (ld_stall !== 1'b0) $display("FAIL hazard_lb_disjoint: got %b want 0", ld_stall); else passed++;
        ld_addr = 32'h0000_2004; ld_byteen = 4'hF;
        #1;
        total++; if (ld_stall !== 1'b0) $display("FAIL hazard_other_word: got %b want 0", ld_stall); else passed++;
        ld_valid = 1'b0;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h0000_2000; ld_byteen = 4'hF;
        #1;
        total++; if (ld_stall !== 1'b0) $display("FAIL hazard_after_ack: got %b want 0", ld_stall); else passed++;
        ld_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_store(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'h5500_0000 + 32'(i));
            tick();
            total++;
            if (count !== 3'd1 || bus_addr !== 32'h100 + 32'(4 * i) || bus_wdata !== 32'h5500_0000 + 32'(i))
                $display("FAIL b2b_%0d: got count %0d %h/%h want 1 %h/%h", i, count, bus_addr, bus_wdata, 32'h100 + 32'(4 * i), 32'h5500_0000 + 32'(i));
            else passed++;
        end
        set_store(1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        bus_ack = 1'b0;
        total++; if (count !== 3'd0) $display("FAIL b2b_final_count: got %0d want 0", count); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_store(1'b1, 32'h200 + 32'(4 * i), 4'hF, 32'h7700_0000 + 32'(i));
            tick();
        end
        set_store(1'b0, 32'h0, 4'h0, 32'h0);
        bus_ack = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus_ack = 1'b0;
        #1;
        total++;
        if ({bus_req, count, empty} !== {1'b0, 3'd0, 1'b1})
            $display("FAIL reset_mid: got req %b count %0d empty %b want 0 0 1", bus_req, count, empty);
        else passed++;
        tick(); tick();
        total++; if (bus_req !== 1'b0) $display("FAIL reset_mid_no_reappear: got %b want 0", bus_req); else passed++;
    endtask

    task automatic test_merge();
        logic [2:0]  exp_cnt;
        logic [3:0]  exp_be;
        logic [15:0] exp_lo;
        exp_cnt = MERGE ? 3'd2 : 3'd3;
        exp_be  = MERGE ? 4'b0011 : 4'b0001;
        exp_lo  = MERGE ? 16'hBBAA : 16'h00AA;
        set_store(1'b1, 32'h40, 4'hF, 32'h1111_1111); tick();
        set_store(1'b1, 32'h44, 4'b0001, 32'h0000_00AA); tick();
        set_store(1'b1, 32'h45, 4'b0010, 32'h0000_BB00); tick();
        set_store(1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        total++; if (count !== exp_cnt) $display("FAIL merge_count: got %0d want %0d", count, exp_cnt); else passed++;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        total++;
        if (bus_addr !== 32'h44 || bus_byteen !== exp_be || bus_wdata[15:0] !== exp_lo)
            $display("FAIL merge_tail: got %h %b %h want 00000044 %b %h", bus_addr, bus_byteen, bus_wdata[15:0], exp_be, exp_lo);
        else passed++;
        bus_ack = 1'b1;
        repeat (3) tick();
        bus_ack = 1'b0;
        #1;
        total++; if (empty !== 1'b1) $display("FAIL merge_drain: got %b want 1", empty); else passed++;
    endtask

    task automatic test_random();
        logic [74:0] obs, exp;
        logic        e_req, e_stall;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 49) != 0);
            st_valid  = ($urandom_range(0, 2) != 0);
            st_addr   = 32'h300 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            st_byteen = 4'($urandom_range(0, 15));
            st_wdata  = $urandom;
            bus_ack   = ($urandom_range(0, 2) == 0);
            ld_valid  = $urandom_range(0, 1) == 1;
            ld_addr   = 32'h300 + 32'($urandom_range(0, 4) * 4);
            ld_byteen = 4'($urandom_range(0, 15));
            #1;
            e_req = (q.size() != 0);
            e_addr = 32'h0; e_be = 4'h0; e_wdata = 32'h0;
            if (e_req) begin
                e_addr = {q[0].a, 2'b00}; e_be = q[0].be; e_wdata = q[0].d;
            end
            e_stall = 1'b0;
            foreach (q[k])
                if (q[k].a == ld_addr[31:2] && (q[k].be & ld_byteen) != 4'h0) e_stall = 1'b1;
            e_stall = e_stall && ld_valid;
            exp = {e_req, e_addr, e_be, e_wdata, (q.size() == 0), 3'(q.size()), model_ready(), e_stall};
            obs = {bus_req, bus_addr, bus_byteen, bus_wdata, empty, count, st_ready, ld_stall};
            total++;
            if (obs !== exp) $display("FAIL random_cycle%0d: got %h want %h", c, obs, exp);
            else passed++;
            tick();
        end
        reset = 1'b1; st_valid = 1'b0; bus_ack = 1'b0; ld_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; bus_ack = 1'b0;
        set_store(1'b0, 32'h0, 4'h0, 32'h0);
        ld_valid = 1'b0; ld_addr = 32'h0; ld_byteen = 4'h0;
        test_reset();
        test_single();
        test_full();
        test_hazard();
        test_back_to_back();
        test_reset_mid();
        test_merge();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/m_store_buffer.md
Name: m_store_buffer

Overview:
- Posted-write buffer sitting directly downstream of the M-stage byte-enable/store-data formatter.
- Accepts formatted stores (word address, byte enables, lane-aligned write data) from the M stage. Retires them in order to the system bridge over a req/ack handshake, so slow targets (DM, timer, UART, digit tube, LEDs) do not stall the pipeline on every store.
- Flags M-stage loads that overlap a pending store so the hazard unit can stall them.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears the block.
- st_valid  input  1  M stage presents a store this cycle.
- st_addr  input  32  store byte address; only bits [31:2] are stored.
- st_byteen  input  4  byte-lane enables from the formatter.
- st_wdata  input  32  lane-aligned write data.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_valid  input  1  M stage is executing a load.
- ld_addr  input  32  load byte address.
- ld_byteen  input  4  lanes read by the load.
- ld_stall  output  1  load overlaps a pending store; hold the load in M.
- bus_req  output  1  head entry is being offered to the bridge.
- bus_addr  output  32  {head word address, 2'b00}.
- bus_byteen  output  4  head byte enables.
- bus_wdata  output  32  head write data.
- bus_ack  input  1  bridge has accepted the offered write this cycle.
- empty  output  1  no entries pending; used to drain before eret/mtc0/syscall.
- count  output  PTR_W+1  number of valid entries.

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr[31:2], byteen, wdata}, with wr_ptr/rd_ptr of PTR_W bits (wrap modulo DEPTH) and a count register of PTR_W+1 bits.
- Reset (reset==0 at clk edge):
  - count=0, pointers=0, and all entries invalid.
  - Outputs: bus_req=0, empty=1, st_ready=1, ld_stall=0.
  - Stores pending at reset are discarded, including a head mid-handshake.
- Push: occurs when st_valid && st_ready && st_byteen!=4'b0000.
  - A store with byteen==0 is a no-op and allocates nothing.
  - st_ready = (count != DEPTH), derived from registered count only; no same-cycle pop bypass.
- Pop: occurs when bus_req && bus_ack. bus_ack while bus_req==0 is ignored.
- Count update:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push only: count+1.
  - Pop only: count-1.
- Bus side:
  - bus_req = (count != 0), registered view, so latency from push into an empty buffer to bus_req is 1 cycle.
  - bus_addr, bus_byteen and bus_wdata are driven from the entry at rd_ptr and stay stable while bus_req is high and bus_ack is low.
  - After a pop with count>1, the next entry is presented in the following cycle with bus_req held high, giving back-to-back retirement of 1 store per cycle.
  - When bus_req==0, the bus_addr, bus_byteen and bus_wdata outputs are 0.
- Ordering: strictly FIFO; no reordering or coalescing unless the optional feature is enabled.
- Load hazard (combinational):
  - ld_stall = ld_valid && there exists a valid entry e with e.addr==ld_addr[31:2] and (e.byteen & ld_byteen)!=0.
  - The in-flight head counts as pending until its ack cycle completes.
  - Disjoint lanes within the same word do not stall.
  - A store being pushed in the same cycle is not compared; the pipeline never has a load and a store in M at once.
- empty = (count==0).
- Full boundary: with count==DEPTH, st_ready=0 and the store is held upstream. st_ready returns to 1 in the cycle after the first pop.

Optional Feature:
- Macro: STBUF_MERGE_EN.
- Enabled: a push whose addr[31:2] equals the tail entry's word address merges into the tail instead of allocating a new entry. Merge rule:
  - New byteen = old | st_byteen.
  - Enabled lanes of wdata are overwritten.
  - Count and pointers are unchanged.
- Merge is allowed only if the tail is not the head currently offered (count>=2); otherwise a normal allocation happens.
- Merge is allowed even when count==DEPTH; in that case st_ready=1 for merging pushes only.
- Disabled: every non-zero push allocates a new entry, and st_ready is as specified above.

Test Plan:
- Reset, then push {addr 0x0000_1004, byteen 1111, wdata 0xDEADBEEF} with bus_ack held 0 -> bus_req=1 next cycle, bus_addr=0x0000_1004, count=1; values stable for 5 cycles; ack -> empty=1 the cycle after.
- Push 4 stores to 0x10,0x14,0x18,0x1C with ack low -> count=4, st_ready=0, 5th store held; one ack -> st_ready=1 next cycle; acks drain in order 0x10..0x1C.
- Pending sb to 0x0000_2002 (byteen 0100): load lw 0x2000 (byteen 1111) -> ld_stall=1; lb 0x2001 (byteen 0010) -> ld_stall=0; after ack, lw -> ld_stall=0.
- Continuous ack with push every cycle (5 stores) -> one bus retirement per cycle, count never exceeds 1, data order preserved.
- reset driven low while count=3 and head mid-handshake -> next cycle bus_req=0, count=0, empty=1; prior entries never reappear.
- STBUF_MERGE_EN: with head at 0x40 stalled, push sb 0x44 lane0 (0xAA) then sb 0x45 lane1 (0xBB) -> count=2, tail byteen 0011, wdata[15:0]=0xBBAA; without the macro -> count=3.
